// File: rtl/fsm_input_conditioner.sv
// Input front-end for the control FSM: synchronises raw_in, debounces it into in_clean,
// and reports registered edge pulses plus a saturating count of rejected glitches.
module fsm_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                raw_in,
    input  logic                enable,
    input  logic                glitch_clr,
    output logic                in_clean,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   in_clean_q, in_clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic                   sync_out;
    logic                   accept;
    logic                   glitch_inc;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        glitch_inc = 1'b0;
        if (!enable) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (sync_out != in_clean_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_CHANGING;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ST_CHANGING: begin
                    if (sync_out == in_clean_q) begin
                        glitch_inc = 1'b1;
                        state_d    = ST_STABLE;
                        cnt_d      = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        accept  = 1'b1;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_clean_d = accept ? sync_out : in_clean_q;
        rise_d     = accept & sync_out;
        fall_d     = accept & ~sync_out;
        glitch_d   = glitch_q;
        // Clear takes priority over a reject landing on the same edge.
        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch_inc && (glitch_q != '1)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            state_q    <= ST_STABLE;
            cnt_q      <= '0;
            in_clean_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            glitch_q   <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_clean_q <= in_clean_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            glitch_q   <= glitch_d;
        end
    end

    assign in_clean   = in_clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = (state_q == ST_CHANGING);
    assign glitch_cnt = glitch_q;

endmodule
